// File: rtl/ibex_fpu_nc_pipe.sv
// ibex_fpu_nc_pipe: pipelined non-computational FP ops (sign-inject, min/max, compare, class, moves)
module ibex_fpu_nc_pipe #(
  parameter int EXP_W = 8,
  parameter int MAN_W = 23,
  parameter int LATENCY = 2,
  localparam int FLEN = 1 + EXP_W + MAN_W
) (
  input  logic            clk_i,
  input  logic            rst_ni,
  input  logic            in_valid_i,
  output logic            in_ready_o,
  input  logic [3:0]      op_i,
  input  logic [FLEN-1:0] rs1_i,
  input  logic [FLEN-1:0] rs2_i,
  input  logic [31:0]     rs1_int_i,
  input  logic [4:0]      rd_addr_i,
  output logic            out_valid_o,
  input  logic            out_ready_i,
  output logic [31:0]     result_o,
  output logic [4:0]      rd_addr_o,
  output logic            fp_we_o,
  output logic            int_we_o,
  output logic            illegal_o,
  input  logic            flush_i,
  output logic [4:0]      fflags_o,
  input  logic            fflags_clr_i
);
  localparam int W = (FLEN < 32) ? FLEN : 32;
  localparam logic [FLEN-1:0] CNAN = {1'b0, {EXP_W{1'b1}}, 1'b1, {(MAN_W-1){1'b0}}};
  typedef struct packed {
    logic [31:0] result;
    logic [4:0]  rd;
    logic        fp_we;
    logic        int_we;
    logic        ill;
    logic        nv;
  } stage_t;
  function automatic logic [9:0] fclass(input logic [FLEN-1:0] x);
    logic s, e1, e0, m0, nan;
    s   = x[FLEN-1];
    e1  = &x[FLEN-2:MAN_W];
    e0  = ~|x[FLEN-2:MAN_W];
    m0  = ~|x[MAN_W-1:0];
    nan = e1 & ~m0;
    return {nan & x[MAN_W-1], nan & ~x[MAN_W-1], ~s & e1 & m0, ~s & ~e1 & ~e0,
            ~s & e0 & ~m0, ~s & e0 & m0, s & e0 & m0, s & e0 & ~m0, s & ~e1 & ~e0, s & e1 & m0};
  endfunction
  logic [9:0] ca, cb;
  logic sa, sb, a_nan, b_nan, any_nan, any_snan, both_zero, lt_tot, lt, eq;
  logic [FLEN-2:0] ma, mb;
  logic [FLEN-1:0] fp_r;
  stage_t s0;
  stage_t st_q [LATENCY];
  logic [LATENCY-1:0] v_q;
  logic nv_q, hs;
  assign ca        = fclass(rs1_i);
  assign cb        = fclass(rs2_i);
  assign sa        = rs1_i[FLEN-1];
  assign sb        = rs2_i[FLEN-1];
  assign ma        = rs1_i[FLEN-2:0];
  assign mb        = rs2_i[FLEN-2:0];
  assign a_nan     = ca[9] | ca[8];
  assign b_nan     = cb[9] | cb[8];
  assign any_nan   = a_nan | b_nan;
  assign any_snan  = ca[8] | cb[8];
  assign both_zero = (ca[4] | ca[3]) & (cb[4] | cb[3]);
  // total order used by MIN/MAX places -0 below +0; IEEE compares then equate the zeros
  assign lt_tot    = (sa != sb) ? sa : (sa ? ma > mb : ma < mb);
  assign lt        = lt_tot & ~both_zero;
  assign eq        = (rs1_i == rs2_i) | both_zero;
  always_comb begin
    fp_r = '0;
    s0 = '0;
    s0.rd = rd_addr_i;
    case (op_i)
      4'd0: fp_r = {sb, ma};
      4'd1: fp_r = {~sb, ma};
      4'd2: fp_r = {sa ^ sb, ma};
      4'd3, 4'd4: fp_r = (a_nan & b_nan) ? CNAN : a_nan ? rs2_i : b_nan ? rs1_i :
                         ((op_i == 4'd3) == lt_tot) ? rs1_i : rs2_i;
      4'd5: s0.result = 32'(~any_nan & eq);
      4'd6: s0.result = 32'(~any_nan & lt);
      4'd7: s0.result = 32'(~any_nan & (lt | eq));
      4'd8: s0.result = 32'(ca);
      4'd9: s0.result = rs1_int_i;
      4'd10: s0.result = 32'(rs1_i[W-1:0]);
      default: s0.ill = 1'b1;
    endcase
    if (op_i <= 4'd4) s0.result = 32'(fp_r[W-1:0]);
    s0.fp_we  = (op_i <= 4'd4) | (op_i == 4'd9);
    s0.int_we = (op_i >= 4'd5) & (op_i <= 4'd8) | (op_i == 4'd10);
    s0.nv     = (op_i >= 4'd3 && op_i <= 4'd5) ? any_snan : (op_i == 4'd6 || op_i == 4'd7) ? any_nan : 1'b0;
  end
  assign out_valid_o = v_q[LATENCY-1];
  assign in_ready_o  = ~flush_i & (~out_valid_o | out_ready_i);
  assign hs          = out_valid_o & out_ready_i;
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      v_q <= '0;
      for (int i = 0; i < LATENCY; i++) st_q[i] <= '0;
    end else if (flush_i) begin
      v_q <= '0;
    end else if (in_ready_o) begin
      v_q[0]  <= in_valid_i;
      st_q[0] <= s0;
      for (int i = 1; i < LATENCY; i++) begin
        v_q[i]  <= v_q[i-1];
        st_q[i] <= st_q[i-1];
      end
    end
  end
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) nv_q <= 1'b0;
    else nv_q <= fflags_clr_i ? (hs & st_q[LATENCY-1].nv) : (nv_q | (hs & st_q[LATENCY-1].nv));
  end
  assign result_o  = st_q[LATENCY-1].result;
  assign rd_addr_o = st_q[LATENCY-1].rd;
  assign fp_we_o   = out_valid_o & st_q[LATENCY-1].fp_we;
  assign int_we_o  = out_valid_o & st_q[LATENCY-1].int_we;
  assign illegal_o = out_valid_o & st_q[LATENCY-1].ill;
  assign fflags_o  = {nv_q, 4'b0};
endmodule

// File: tb/tb_ibex_fpu_nc_pipe.sv
// tb_ibex_fpu_nc_pipe: vector table plus stall/flush/reset sequences, scoreboard queue on outputs
module tb_ibex_fpu_nc_pipe;
  typedef struct {
    logic [3:0]  op;
    logic [31:0] a, b, i, r;
    logic        fw, iw, il, nv;
  } vec_t;
  typedef struct {
    logic [31:0] r;
    logic [4:0]  rd;
    logic        fw, iw, il, nv;
  } exp_t;
  logic clk = 0, rst_n = 0;
  logic in_valid = 0, out_ready = 1, flush = 0, fflags_clr = 0;
  logic [3:0] op = 0;
  logic [31:0] rs1 = 0, rs2 = 0, rs1_int = 0;
  logic [4:0] rd_addr = 0;
  logic in_ready_o, out_valid_o, fp_we_o, int_we_o, illegal_o;
  logic [31:0] result_o;
  logic [4:0] rd_addr_o, fflags_o;
  logic [4:0] exp_flags = 0;
  logic mon_nv;
  int tests = 0, fails = 0;
  vec_t vt[$];
  exp_t q[$];
  always #5 clk = ~clk;
  ibex_fpu_nc_pipe dut (
    .clk_i(clk), .rst_ni(rst_n), .in_valid_i(in_valid), .in_ready_o(in_ready_o),
    .op_i(op), .rs1_i(rs1), .rs2_i(rs2), .rs1_int_i(rs1_int), .rd_addr_i(rd_addr),
    .out_valid_o(out_valid_o), .out_ready_i(out_ready), .result_o(result_o),
    .rd_addr_o(rd_addr_o), .fp_we_o(fp_we_o), .int_we_o(int_we_o), .illegal_o(illegal_o),
    .flush_i(flush), .fflags_o(fflags_o), .fflags_clr_i(fflags_clr)
  );
  task automatic chk(input string n, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h expected %h", n, act, exp);
    end
  endtask
  task automatic add(input logic [3:0] o, input logic [31:0] a, b, i, r, input logic fw, iw, il, nv);
    vec_t v;
    v = '{o, a, b, i, r, fw, iw, il, nv};
    vt.push_back(v);
  endtask
  task automatic drive(input vec_t v, input logic [4:0] rd);
    int n;
    exp_t e;
    n = 0;
    in_valid = 1; op = v.op; rs1 = v.a; rs2 = v.b; rs1_int = v.i; rd_addr = rd;
    #1;
    while (!in_ready_o && n < 50) begin @(posedge clk); #2; n++; end
    if (in_ready_o) begin
      e = '{v.r, rd, v.fw, v.iw, v.il, v.nv};
      q.push_back(e);
    end else chk("accept_timeout", 32'(in_ready_o), 32'd1);
    @(posedge clk); #1;
    in_valid = 0;
  endtask
  task automatic drain();
    int n;
    n = 0;
    while (q.size() != 0 && n < 100) begin @(posedge clk); n++; end
    chk("drain", q.size(), 0);
    @(posedge clk); #1;
  endtask
  task automatic pulse_clr();
    @(posedge clk); #1 fflags_clr = 1;
    @(posedge clk); #1 fflags_clr = 0;
  endtask
  always @(negedge clk) if (rst_n) begin
    chk("fflags", 32'(fflags_o), 32'(exp_flags));
    mon_nv = 1'b0;
    if (out_valid_o) begin
      if (q.size() == 0) chk("unexpected_output", 32'(out_valid_o), 32'd0);
      else begin
        chk("result", result_o, q[0].r);
        chk("rd", 32'(rd_addr_o), 32'(q[0].rd));
        chk("we_ill", 32'({fp_we_o, int_we_o, illegal_o}), 32'({q[0].fw, q[0].iw, q[0].il}));
        if (out_ready) begin mon_nv = q[0].nv; void'(q.pop_front()); end
      end
      if (!out_ready) chk("in_ready_stall", 32'(in_ready_o), 32'd0);
    end else chk("we_gated", 32'({fp_we_o, int_we_o, illegal_o}), 32'd0);
    exp_flags = fflags_clr ? {mon_nv, 4'b0} : (exp_flags | {mon_nv, 4'b0});
  end
  initial begin
    int n;
    add(0, 32'h3F800000, 32'h80000000, 0, 32'hBF800000, 1, 0, 0, 0);
    add(1, 32'h3F800000, 32'h80000000, 0, 32'h3F800000, 1, 0, 0, 0);
    add(2, 32'hBF800000, 32'h80000000, 0, 32'h3F800000, 1, 0, 0, 0);
    add(3, 32'h80000000, 32'h00000000, 0, 32'h80000000, 1, 0, 0, 0);
    add(4, 32'h80000000, 32'h00000000, 0, 32'h00000000, 1, 0, 0, 0);
    add(3, 32'h7FC00000, 32'h40000000, 0, 32'h40000000, 1, 0, 0, 0);
    add(4, 32'h7F800001, 32'h40000000, 0, 32'h40000000, 1, 0, 0, 1);
    add(3, 32'hFFC00000, 32'h7FC00001, 0, 32'h7FC00000, 1, 0, 0, 0);
    add(3, 32'hC0000000, 32'hBF800000, 0, 32'hC0000000, 1, 0, 0, 0);
    add(4, 32'hC0000000, 32'hBF800000, 0, 32'hBF800000, 1, 0, 0, 0);
    add(5, 32'h00000000, 32'h80000000, 0, 32'h1, 0, 1, 0, 0);
    add(5, 32'h7FC00000, 32'h7FC00000, 0, 32'h0, 0, 1, 0, 0);
    add(5, 32'h7F800001, 32'h3F800000, 0, 32'h0, 0, 1, 0, 1);
    add(6, 32'h7F800001, 32'h3F800000, 0, 32'h0, 0, 1, 0, 1);
    add(6, 32'hBF800000, 32'h3F800000, 0, 32'h1, 0, 1, 0, 0);
    add(6, 32'h80000000, 32'h00000000, 0, 32'h0, 0, 1, 0, 0);
    add(7, 32'h80000000, 32'h00000000, 0, 32'h1, 0, 1, 0, 0);
    add(7, 32'h40000000, 32'h3F800000, 0, 32'h0, 0, 1, 0, 0);
    add(6, 32'h7FC00000, 32'h3F800000, 0, 32'h0, 0, 1, 0, 1);
    add(8, 32'hFF800000, 0, 0, 32'h001, 0, 1, 0, 0);
    add(8, 32'h00000001, 0, 0, 32'h020, 0, 1, 0, 0);
    add(8, 32'h7FC00000, 0, 0, 32'h200, 0, 1, 0, 0);
    add(8, 32'h7F800001, 0, 0, 32'h100, 0, 1, 0, 0);
    add(8, 32'h80000000, 0, 0, 32'h008, 0, 1, 0, 0);
    add(8, 32'h3F800000, 0, 0, 32'h040, 0, 1, 0, 0);
    add(9, 0, 0, 32'hDEADBEEF, 32'hDEADBEEF, 1, 0, 0, 0);
    add(10, 32'h12345678, 0, 0, 32'h12345678, 0, 1, 0, 0);
    add(13, 32'h3F800000, 32'h3F800000, 32'h1, 32'h0, 0, 0, 1, 0);
    add(11, 32'h3F800000, 0, 0, 32'h0, 0, 0, 1, 0);
    add(15, 32'hFFFFFFFF, 0, 0, 32'h0, 0, 0, 1, 0);
    repeat (3) @(posedge clk);
    #1 rst_n = 1;
    #1;
    chk("reset_in_ready", 32'(in_ready_o), 32'd1);
    chk("reset_out_valid", 32'(out_valid_o), 32'd0);
    chk("reset_result", result_o, 32'd0);
    chk("reset_fflags", 32'(fflags_o), 32'd0);
    @(posedge clk); #1;
    // exact latency of a MIN with -0/+0
    drive(vt[3], 5'd1);
    chk("lat_cycle1_valid", 32'(out_valid_o), 32'd0);
    @(posedge clk); #1;
    chk("lat_cycle2_valid", 32'(out_valid_o), 32'd1);
    chk("lat_result", result_o, 32'h80000000);
    chk("lat_fp_we", 32'(fp_we_o), 32'd1);
    drain();
    foreach (vt[k]) drive(vt[k], 5'(k));
    drain();
    // sticky NV from LT on sNaN, then clear
    pulse_clr();
    drive(vt[13], 5'd7);
    drain();
    chk("lt_snan_flags", 32'(fflags_o), 32'h10);
    pulse_clr();
    #1 chk("flags_cleared", 32'(fflags_o), 32'd0);
    // back-to-back with a 3-cycle stall
    fork
      begin
        drive(vt[14], 5'd20); drive(vt[16], 5'd21); drive(vt[20], 5'd22); drive(vt[25], 5'd23);
      end
      begin
        repeat (2) @(posedge clk);
        #1 out_ready = 0;
        #2 chk("stall_in_ready", 32'(in_ready_o), 32'd0);
        repeat (3) @(posedge clk);
        #1 out_ready = 1;
      end
    join
    drain();
    // flush with two ops in flight
    out_ready = 0;
    drive(vt[12], 5'd10);
    drive(vt[18], 5'd11);
    flush = 1; in_valid = 1; op = 4'd6; rs1 = 32'h7FC00000; rs2 = 0;
    #1 chk("flush_in_ready", 32'(in_ready_o), 32'd0);
    @(posedge clk); #1;
    flush = 0; in_valid = 0; out_ready = 1;
    q.delete();
    repeat (3) begin
      @(posedge clk); #1 chk("flush_no_output", 32'(out_valid_o), 32'd0);
    end
    chk("flush_no_flags", 32'(fflags_o), 32'd0);
    drive(vt[0], 5'd12);
    drain();
    // async reset while an output is stalled
    drive(vt[6], 5'd13);
    drain();
    out_ready = 0;
    drive(vt[1], 5'd14);
    n = 0;
    while (!out_valid_o && n < 10) begin @(posedge clk); #1; n++; end
    chk("stalled_valid", 32'(out_valid_o), 32'd1);
    #2 rst_n = 0;
    q.delete();
    exp_flags = 0;
    #1;
    chk("rst_outputs", 32'({out_valid_o, fp_we_o, int_we_o, illegal_o}), 32'd0);
    chk("rst_result", result_o, 32'd0);
    chk("rst_rd", 32'(rd_addr_o), 32'd0);
    chk("rst_fflags", 32'(fflags_o), 32'd0);
    @(posedge clk); #1 rst_n = 1; out_ready = 1;
    #1 chk("post_rst_ready", 32'(in_ready_o), 32'd1);
    @(posedge clk); #1;
    drive(vt[26], 5'd15);
    drain();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule

// File: doc/ibex_fpu_nc_pipe.md
IBEX_FPU_NC_PIPE -- requirements
Module: ibex_fpu_nc_pipe

Interface
REQ-001 SHALL have parameter EXP_W, default 8, exponent width.
REQ-002 SHALL have parameter MAN_W, default 23, mantissa width; FLEN = 1+EXP_W+MAN_W.
REQ-003 SHALL have parameter LATENCY, default 2, pipeline depth in cycles, legal range 1..4.
REQ-004 SHALL have ports: clk_i input 1, clock; rst_ni input 1, reset (asynchronous, active-low).
REQ-005 SHALL have ports: in_valid_i input 1, request valid; in_ready_o output 1, request accepted when both high.
REQ-006 SHALL have ports: op_i input 4, operation; rs1_i, rs2_i input FLEN, fp operands; rs1_int_i input 32, int operand; rd_addr_i input 5, destination.
REQ-007 SHALL have ports: out_valid_o output 1; out_ready_i input 1; result_o output 32; rd_addr_o output 5; fp_we_o output 1; int_we_o output 1; illegal_o output 1.
REQ-008 SHALL have ports: flush_i input 1, discard in-flight ops; fflags_o output 5 sticky {NV,DZ,OF,UF,NX}; fflags_clr_i input 1.

Function
REQ-009 SHALL decode op_i: 0 SGNJ, 1 SGNJN, 2 SGNJX, 3 MIN, 4 MAX, 5 EQ, 6 LT, 7 LE, 8 CLASS, 9 MV_X2F, 10 MV_F2X; 11-15 illegal.
REQ-010 SHALL produce SGNJ/SGNJN/SGNJX as rs1 magnitude with sign rs2, ~rs2, rs1^rs2; fp_we_o=1.
REQ-011 SHALL produce MIN/MAX treating -0 < +0; one NaN operand returns the other; both NaN returns canonical NaN (0x7FC00000 at defaults); fp_we_o=1.
REQ-012 SHALL produce EQ/LT/LE as zero-extended 1-bit result; any NaN operand gives 0; int_we_o=1.
REQ-013 SHALL set NV for MIN/MAX/EQ when any operand is signalling NaN, and for LT/LE when any operand is NaN.
REQ-014 SHALL produce CLASS as 10-bit one-hot RISC-V class mask zero-extended; int_we_o=1.
REQ-015 SHALL produce MV_X2F as rs1_int_i (fp_we_o=1) and MV_F2X as rs1_i low 32 bits (int_we_o=1).
REQ-016 SHALL, for illegal op, output result 0, fp_we_o=int_we_o=0, illegal_o=1, no flags.
REQ-017 SHALL compute result in stage 0 and carry it through LATENCY registered stages; accepted op appears on out_valid_o exactly LATENCY cycles later absent stall.
REQ-018 SHALL stall the whole pipeline when out_valid_o=1 and out_ready_i=0; in_ready_o = ~out_valid_o | out_ready_i.
REQ-019 SHALL collapse bubbles only by global advance: all stages shift when in_ready_o=1, empty stages carry valid=0.
REQ-020 SHALL hold result_o, rd_addr_o, we and illegal outputs stable while out_valid_o=1 and out_ready_i=0.
REQ-021 SHALL gate fp_we_o/int_we_o/illegal_o with out_valid_o (all 0 when out_valid_o=0).
REQ-022 SHALL, on flush_i, clear all stage valid bits next cycle and not accept an op presented that cycle; in_ready_o forced 0 during flush_i.
REQ-023 SHALL OR an output's flags into fflags_o only at output handshake (out_valid_o & out_ready_i).
REQ-024 SHALL, on fflags_clr_i with a same-cycle handshake, leave fflags_o equal to that handshake's flags only.
REQ-025 SHALL keep DZ, OF, UF, NX permanently 0 (no op in this block raises them).

Reset
REQ-026 SHALL on rst_ni=0 clear all stage valids, fflags_o=0, out_valid_o=0, result_o=0, rd_addr_o=0, all we/illegal 0, asynchronously; in-flight ops are lost.
REQ-027 SHALL drive in_ready_o=1 in the first cycle after reset release.

Verification
REQ-028 SHALL test: LATENCY=2, op MIN, rs1=0x80000000, rs2=0x00000000, out_ready_i=1 -> out_valid_o after 2 cycles, result_o=0x80000000, fp_we_o=1.
REQ-029 SHALL test: op LT, rs1=0x7F800001 (sNaN), rs2=0x3F800000 -> result_o=0, int_we_o=1, fflags_o=5'b10000 after handshake; then fflags_clr_i -> 0.
REQ-030 SHALL test: back-to-back 4 ops with out_ready_i low 3 cycles mid-stream -> in_ready_o low while stalled, all 4 results in order, none duplicated or dropped.
REQ-031 SHALL test: flush_i asserted with 2 ops in flight -> out_valid_o stays 0, no flag update, next op completes normally.
REQ-032 SHALL test: op CLASS, rs1=0xFF800000 -> result_o=0x00000001; op 13 -> illegal_o=1, no write enables.
REQ-033 SHALL test: rst_ni dropped mid-stall with out_valid_o=1 -> all outputs 0 immediately, fflags_o=0.
